univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_if.sv | 39 +++
 rtl/univ_shift_reg.sv | 117 +++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// ============================================================================
// Module      : univ_shift_reg_if
// Description : Control/data bundle for the universal shift register.
//               The master drives mode/burst controls and observes the
//               register state; the slave is the shift register itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) ();
    logic             en;
    logic [1:0]       mode;
    logic             si_r;
    logic             si_l;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic             burst_dir;
    logic [LEN_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, si_r, si_l, pdata, start, burst_dir, burst_len,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  en, mode, si_r, si_l, pdata, start, burst_dir, burst_len,
        output q, so_r, so_l, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register with manual hold/shift/load modes
//               and an automatic burst engine that performs a counted run
//               of shifts in a latched direction, reporting busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    univ_shift_reg_if.slave  sr
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Longest burst that makes sense: every bit shifted out once.
    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_shift_r;
    logic [WIDTH-1:0]   w_shift_l;
    logic [LEN_W-1:0]   w_len_clamp;

    assign w_shift_r   = {sr.si_r, r_q[WIDTH-1:1]};
    assign w_shift_l   = {r_q[WIDTH-2:0], sr.si_l};
    assign w_len_clamp = (sr.burst_len > c_len_max) ? c_len_max : sr.burst_len;

    // Next-state logic: manual modes in IDLE, counted shifts in RUN.
    // A zero-length burst still spends one cycle in RUN so that busy and
    // done keep the same shape as a real burst.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (sr.en) begin
            case (r_state)
                S_IDLE: begin
                    if (sr.start) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_len_clamp;
                        w_dir_nxt   = sr.burst_dir;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        case (sr.mode)
                            2'b01:   w_q_nxt = w_shift_r;
                            2'b10:   w_q_nxt = w_shift_l;
                            2'b11:   w_q_nxt = sr.pdata;
                            default: w_q_nxt = r_q;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0) begin
                        w_q_nxt   = r_dir ? w_shift_l : w_shift_r;
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                    end
                    if (r_cnt <= LEN_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register; reset clears everything including an in-flight burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign sr.q    = r_q;
    assign sr.so_r = r_q[0];
    assign sr.so_l = r_q[WIDTH-1];
    assign sr.busy = r_busy;
    assign sr.done = r_done;

endmodule

`default_nettype wire
